// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: exception codes,
// text-segment bounds and the F->D register bundle.
package mips_pkg;

    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    localparam logic [31:0] TEXT_BASE  = 32'h0000_3000;
    localparam logic [31:0] TEXT_END   = 32'h0000_6FFF;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam logic [31:0] NOP_WORD   = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exccode;
        logic        bd;
        logic        valid;
    } fd_t;

    // Bubble carrying a PC but no instruction.
    function automatic fd_t fd_bubble(input logic [31:0] pc);
        fd_t b;
        b.pc      = pc;
        b.instr   = NOP_WORD;
        b.exccode = EXC_NONE;
        b.bd      = 1'b0;
        b.valid   = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_exc_check.sv
// Fetch address check: flags misaligned or
// out-of-text-segment fetch addresses (AdEL).
module fetch_exc_check
    import mips_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = mips_pkg::TEXT_BASE,
    parameter logic [31:0] TEXT_END  = mips_pkg::TEXT_END
) (
    input  logic [31:0] F_pc,
    output logic        adel
);

    // Unsigned 32-bit compares, so high addresses never wrap to legal.
    always_comb begin
        adel = (F_pc[1:0] != 2'b00)
             | (F_pc < TEXT_BASE)
             | (F_pc > TEXT_END);
    end

endmodule

// File: rtl/fd_stage_reg.sv
// Fetch-to-decode pipeline register with AdEL tagging,
// delay-slot marking and stall/flush/Req bubbles.
module fd_stage_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter logic [31:0] HANDLER_PC = mips_pkg::HANDLER_PC,
    parameter logic [31:0] TEXT_BASE  = mips_pkg::TEXT_BASE,
    parameter logic [31:0] TEXT_END   = mips_pkg::TEXT_END
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Req,
    input  logic        flush,
    input  logic [31:0] F_pc,
    input  logic [31:0] F_instr,
    input  logic        D_is_jump,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic [4:0]  D_exccode,
    output logic        D_bd,
    output logic        D_valid
);

    logic adel;
    fd_t  d_q;
    fd_t  load_v;

    fetch_exc_check #(
        .TEXT_BASE (TEXT_BASE),
        .TEXT_END  (TEXT_END)
    ) u_exc (
        .F_pc (F_pc),
        .adel (adel)
    );

    // Entry built from F; a faulting fetch keeps its PC but drops its word.
    always_comb begin
        load_v.pc      = F_pc;
        load_v.bd      = D_is_jump;
        load_v.valid   = 1'b1;
        load_v.instr   = adel ? NOP_WORD : F_instr;
        load_v.exccode = adel ? EXC_ADEL : EXC_NONE;
    end

    // Priority: Req > stall > flush > load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= fd_bubble(RESET_PC);
        end else if (Req) begin
            d_q <= fd_bubble(HANDLER_PC);
        end else if (stall) begin
            d_q <= d_q;
        end else if (flush) begin
            d_q <= fd_bubble(F_pc);
        end else begin
            d_q <= load_v;
        end
    end

    assign D_pc      = d_q.pc;
    assign D_instr   = d_q.instr;
    assign D_exccode = d_q.exccode;
    assign D_bd      = d_q.bd;
    assign D_valid   = d_q.valid;

endmodule

// File: tb/tb_fd_stage_reg.sv
// Randomized self-checking bench for fd_stage_reg
// against a rule-level reference model.
module tb_fd_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, Req, flush, D_is_jump;
    logic [31:0] F_pc, F_instr;
    logic [31:0] D_pc, D_instr;
    logic [4:0]  D_exccode;
    logic        D_bd, D_valid;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    logic [31:0] m_pc, m_instr;
    logic [4:0]  m_exc;
    logic        m_bd, m_valid;

    fd_stage_reg dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .Req       (Req),
        .flush     (flush),
        .F_pc      (F_pc),
        .F_instr   (F_instr),
        .D_is_jump (D_is_jump),
        .D_pc      (D_pc),
        .D_instr   (D_instr),
        .D_exccode (D_exccode),
        .D_bd      (D_bd),
        .D_valid   (D_valid)
    );

    always #5 clk = ~clk;

    function automatic bit bad_fetch(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFF);
    endfunction

    function automatic logic [70:0] got();
        return {D_pc, D_instr, D_exccode, D_bd, D_valid};
    endfunction

    function automatic logic [70:0] want();
        return {m_pc, m_instr, m_exc, m_bd, m_valid};
    endfunction

    task automatic model_bubble(input logic [31:0] pc);
        m_pc = pc; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
    endtask

    // One rising edge; the model applies the same rules at that edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_bubble(32'h3000);
        else if (Req) model_bubble(32'h4180);
        else if (stall) begin end
        else if (flush) model_bubble(F_pc);
        else begin
            m_pc    = F_pc;
            m_bd    = D_is_jump;
            m_valid = 1;
            if (bad_fetch(F_pc)) begin m_instr = 0; m_exc = 4; end
            else begin m_instr = F_instr; m_exc = 0; end
        end
        #1;
    endtask

    task automatic drive(input logic s, r, f, j,
                         input logic [31:0] pc, ins);
        @(negedge clk);
        stall = s; Req = r; flush = f; D_is_jump = j;
        F_pc = pc; F_instr = ins;
    endtask

    task automatic test_reset();
        reset = 0;
        drive(0, 0, 0, 0, 32'h3004, 32'h1234_5678);
        model_bubble(32'h3000);
        tick();
        compared++;
        if (got() !== {32'h3000, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got %h want %h", got(),
                     {32'h3000, 32'h0, 5'd0, 1'b0, 1'b0});
        end
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_load();
        drive(0, 0, 0, 1, 32'h3004, 32'h3C01_1234);
        tick();
        compared++;
        if (got() !== {32'h3004, 32'h3C01_1234, 5'd0, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL load_basic: got %h want %h", got(),
                     {32'h3004, 32'h3C01_1234, 5'd0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_adel();
        logic [31:0] pcs [2];
        pcs[0] = 32'h3006;
        pcs[1] = 32'h7000;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, pcs[i], 32'hDEAD_BEEF);
            tick();
            compared++;
            if (got() !== {pcs[i], 32'h0, 5'd4, 1'b0, 1'b1}) begin
                mismatched++;
                $display("FAIL adel_%0d: got %h want %h", i, got(),
                         {pcs[i], 32'h0, 5'd4, 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_stall();
        drive(0, 0, 0, 1, 32'h3008, 32'hAAAA_0001);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, i == 1, 0, 32'h3100 + 4 * i, $urandom);
            tick();
            compared++;
            if (D_pc !== 32'h3008 || D_bd !== 1'b1 ||
                D_instr !== 32'hAAAA_0001) begin
                mismatched++;
                $display("FAIL stall_hold_%0d: got pc=%h bd=%b ins=%h want pc=3008 bd=1 ins=aaaa0001",
                         i, D_pc, D_bd, D_instr);
            end
        end
        drive(0, 0, 0, 0, 32'h3200, 32'h0BAD_F00D);
        tick();
        compared++;
        if (got() !== {32'h3200, 32'h0BAD_F00D, 5'd0, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL stall_release: got %h want %h", got(),
                     {32'h3200, 32'h0BAD_F00D, 5'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_priority();
        drive(1, 1, 1, 1, 32'h3300, 32'h1111_1111);
        tick();
        compared++;
        if (got() !== {32'h4180, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL req_priority: got %h want %h", got(),
                     {32'h4180, 32'h0, 5'd0, 1'b0, 1'b0});
        end
        drive(1, 0, 1, 0, 32'h3304, 32'h2222_2222);
        tick();
        compared++;
        if (got() !== {32'h4180, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL stall_over_flush: got %h want %h", got(),
                     {32'h4180, 32'h0, 5'd0, 1'b0, 1'b0});
        end
        drive(0, 0, 1, 1, 32'h3308, 32'h3333_3333);
        tick();
        compared++;
        if (got() !== {32'h3308, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL flush: got %h want %h", got(),
                     {32'h3308, 32'h0, 5'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_sweep();
        logic [31:0] pcs [5];
        logic [4:0]  exc [5];
        pcs[0] = 32'h2FFC;     exc[0] = 5'd4;
        pcs[1] = 32'h3000;     exc[1] = 5'd0;
        pcs[2] = 32'h6FFC;     exc[2] = 5'd0;
        pcs[3] = 32'h7000;     exc[3] = 5'd4;
        pcs[4] = 32'hFFFF_FFFC; exc[4] = 5'd4;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, pcs[i], 32'h2400_0001 + i);
            tick();
            compared++;
            if (D_exccode !== exc[i] || D_pc !== pcs[i]) begin
                mismatched++;
                $display("FAIL sweep_%h: got exc=%0d pc=%h want exc=%0d pc=%h",
                         pcs[i], D_exccode, D_pc, exc[i], pcs[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 0, 0, 32'h3400, 32'h5555_5555);
        tick();
        drive(1, 1, 0, 1, 32'h3404, 32'h6666_6666);
        #2;
        reset = 0;
        model_bubble(32'h3000);
        #1;
        compared++;
        if (got() !== want()) begin
            mismatched++;
            $display("FAIL async_reset: got %h want %h", got(), want());
        end
        tick();
        compared++;
        if (got() !== want()) begin
            mismatched++;
            $display("FAIL reset_held: got %h want %h", got(), want());
        end
        drive(0, 0, 0, 0, 32'h3408, 32'h7777_7777);
        reset = 1;
        #1;
        compared++;
        if (got() !== {32'h3000, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_release_wait: got %h want %h", got(),
                     {32'h3000, 32'h0, 5'd0, 1'b0, 1'b0});
        end
        tick();
        compared++;
        if (got() !== want()) begin
            mismatched++;
            $display("FAIL reset_release_load: got %h want %h", got(), want());
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: pc = $urandom_range(32'h2FF0, 32'h7010);
                1: pc = $urandom_range(32'h3000, 32'h6FFF) & ~32'h3;
                2: pc = $urandom;
                default: pc = 32'h6FF0 + 4 * $urandom_range(0, 8);
            endcase
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                  pc, $urandom);
            tick();
            compared++;
            if (got() !== want()) begin
                mismatched++;
                $display("FAIL random_%0d: got %h want %h", i, got(), want());
            end
        end
    endtask

    initial begin
        reset = 0; stall = 0; Req = 0; flush = 0; D_is_jump = 0;
        F_pc = 0; F_instr = 0;
        model_bubble(32'h3000);
        test_reset();
        test_load();
        test_adel();
        test_stall();
        test_priority();
        test_sweep();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fd_stage_reg.md
Name: fd_stage_reg

Overview:
- Fetch-to-decode pipeline register, directly downstream of the PC register. It captures the fetched PC and instruction word into the D stage.
- Detects fetch exceptions (AdEL) and tags branch-delay-slot instructions.
- Inserts bubbles on stall, on flush (eret), and on exception/interrupt request (Req).
- Its outputs feed the decoder, the hazard unit and the exception pipe toward CP0.

Parameters:
- RESET_PC, 32'h0000_3000, D_pc value of the reset bubble.
- HANDLER_PC, 32'h0000_4180, D_pc value of the bubble inserted on Req.
- TEXT_BASE, 32'h0000_3000, lowest legal fetch address.
- TEXT_END, 32'h0000_6FFF, highest legal fetch byte address.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- stall  in  1  hazard-unit stall; D register holds.
- Req  in  1  exception/interrupt taken this cycle; D becomes a handler bubble.
- flush  in  1  discard the F instruction (eret in D; eret has no delay slot).
- F_pc  in  32  current PC from the PC register.
- F_instr  in  32  instruction word from instruction memory at F_pc.
- D_is_jump  in  1  instruction currently in D is a branch or jump, so the F instruction is its delay slot.
- D_pc  out  32  PC of the D instruction.
- D_instr  out  32  instruction in D (0 = nop/bubble).
- D_exccode  out  5  fetch exception code carried with the D instruction (0 = none, 4 = AdEL).
- D_bd  out  1  D instruction is in a branch delay slot.
- D_valid  out  1  D holds a real fetched instruction, not a bubble.

Behaviour:
- Reset (reset==0, asynchronous, overrides everything):
  - D_pc=RESET_PC, D_instr=0, D_exccode=0, D_bd=0, D_valid=0.
  - Deassertion takes effect at the next rising edge.
- Each rising edge, one action is taken, in priority order Req > stall > flush > load:
  - Req: D_pc=HANDLER_PC, D_instr=0, D_exccode=0, D_bd=0, D_valid=0. Overrides a simultaneous stall.
  - stall: all outputs hold their previous values; flush is ignored while stall is set.
  - flush: D_pc=F_pc, D_instr=0, D_exccode=0, D_bd=0, D_valid=0.
  - load: D_pc=F_pc, D_bd=D_is_jump (sampled at this edge), D_valid=1, and:
    - if adel: D_instr=0, D_exccode=4;
    - otherwise: D_instr=F_instr, D_exccode=0.
- Address error check (combinational on F_pc):
  - adel = (F_pc[1:0]!=2'b00) | (F_pc < TEXT_BASE) | (F_pc > TEXT_END).
  - Comparisons are 32-bit unsigned.
  - An AdEL instruction keeps its real F_pc, so CP0 can load EPC/BadVAddr from D_pc; its word is zeroed so no side effect can decode.
- Latency: exactly one cycle from F to D. No combinational path from any input to any output.
- Boundary cases:
  - F_pc=TEXT_END-3 (32'h6FFC) is legal.
  - 32'h7000 is AdEL.
  - 32'h2FFC is AdEL.
  - F_pc=32'hFFFF_FFFC: unsigned compare flags AdEL, with no wrap.
  - A D_bd bit captured during a stall is not re-sampled; the held value stands.
  - A stall lasting N cycles holds for exactly N edges. The first non-stalled edge performs the load (or the flush if flush is set).
  - Reset asserted mid-stall or mid-Req clears immediately, without waiting for clk.

Decomposition:
- Shared package (mips_pkg):
  - EXC_NONE=5'd0, EXC_ADEL=5'd4;
  - TEXT_BASE, TEXT_END, RESET_PC, HANDLER_PC;
  - NOP_WORD=32'h0.
- One natural sub-module: fetch_exc_check. It is combinational: F_pc in, adel out. The other fetch-address checks reuse it.

Test Plan:
- Reset low mid-run with D_valid=1 -> outputs go to 3000/0/0/0/0 before the next clk edge, and stay there until reset is high and an edge occurs.
- F_pc=32'h3004, F_instr=32'h3C01_1234, D_is_jump=1, other controls 0 -> next edge: D_pc=3004, D_instr=3C011234, D_bd=1, D_exccode=0, D_valid=1.
- F_pc=32'h3006 (misaligned), then F_pc=32'h7000 -> each gives D_instr=0, D_exccode=4, D_valid=1, D_pc equal to the faulting PC.
- Load 32'h3008, then stall=1 for 3 edges while F_pc changes -> D holds 3008 for 3 edges, then loads the new F_pc on the 4th edge.
- stall=1, flush=1, Req=1 together -> D_pc=4180, D_instr=0, D_valid=0. Then Req=0, stall=1, flush=1 -> hold. Then stall=0, flush=1 -> D_instr=0, D_pc=F_pc.
- Sweep F_pc across 2FFC, 3000, 6FFC, 7000 and FFFFFFFC -> D_exccode equals 4, 0, 0, 4, 4 respectively.
